// File: rtl/zbus_bufchan_pkg.sv
// zbus_bufchan_pkg: shared state encoding and synchroniser depths for the buffered ZX-bus channel
package zbus_bufchan_pkg;
    typedef enum logic [1:0] {IDLE, ACTIVE, RECOVER, WAIT_REL} state_t;
    localparam int STB_SYNC = 3;
    localparam int REQ_SYNC = 2;
    localparam int REL_HOLD = STB_SYNC - 1;
endpackage

// File: rtl/zbus_strobe_sync.sv
// zbus_strobe_sync: 3-stage resync of one active-low Z80 strobe with filtered edge and release detect
module zbus_strobe_sync
    import zbus_bufchan_pkg::*;
(
    input  logic fclk,
    input  logic rst,
    input  logic strobe_n,
    output logic rise,
    output logic rel
);
    logic [STB_SYNC-1:0] s;
    // shift the inverted strobe in; s[0] is the newest sample
    always_ff @(posedge fclk) begin
        if (rst) s <= '0;
        else     s <= {s[STB_SYNC-2:0], ~strobe_n};
    end
    // rising edge needs two consecutive asserted samples, so a single-sample glitch never starts an access
    always_comb begin
        rise = s[2:0] == 3'b011;
        rel  = s[2:1] == 2'b00;
    end
endmodule

// File: rtl/zbus_bufchan.sv
// zbus_bufchan: issues one fixed-width strobe per Z80 access to buffered bus chips with a recovery gap
module zbus_bufchan
    import zbus_bufchan_pkg::*;
#(
    parameter int NCH     = 2,
    parameter int AW      = 10,
    parameter int DW      = 8,
    parameter int STB_LEN = 5,
    parameter int REC_LEN = 1
) (
    input  logic           fclk,
    input  logic           rst,
    input  logic           zrd_n,
    input  logic           zwr_n,
    input  logic [NCH-1:0] req_cs_n,
    input  logic [AW-1:0]  req_addr,
    input  logic [DW-1:0]  zd_in,
    input  logic [DW-1:0]  bd_in,
    output logic [NCH-1:0] bcs_n,
    output logic [AW-1:0]  baddr,
    output logic           brd_n,
    output logic           bwr_n,
    output logic [DW-1:0]  bd_out,
    output logic           bd_oe,
    output logic [DW-1:0]  rd_data,
    output logic           rd_valid,
    output logic           busy,
    output logic           nosel_err
);
    localparam int CW = $clog2(STB_LEN + REC_LEN + 1);
    logic           rd_rise, rd_rel, wr_rise, wr_rel, wr_acc;
    logic [NCH-1:0] cs_s1, cs_s2;
    logic [AW-1:0]  addr_s1, addr_s2;
    logic [CW-1:0]  cnt;
    state_t         state;

    zbus_strobe_sync u_rd (.fclk(fclk), .rst(rst), .strobe_n(zrd_n), .rise(rd_rise), .rel(rd_rel));
    zbus_strobe_sync u_wr (.fclk(fclk), .rst(rst), .strobe_n(zwr_n), .rise(wr_rise), .rel(wr_rel));

    // two-stage resync of the decode chip-select and address
    always_ff @(posedge fclk) begin
        if (rst) begin
            cs_s1   <= '0;
            cs_s2   <= '0;
            addr_s1 <= '0;
            addr_s2 <= '0;
        end else begin
            cs_s1   <= req_cs_n;
            cs_s2   <= cs_s1;
            addr_s1 <= req_addr;
            addr_s2 <= addr_s1;
        end
    end

    // access sequencer; after reset it waits out the sync pipeline so a strobe live at reset is not re-issued
    always_ff @(posedge fclk) begin
        if (rst) begin
            state     <= WAIT_REL;
            cnt       <= CW'(REL_HOLD);
            wr_acc    <= 1'b0;
            bcs_n     <= '1;
            baddr     <= '0;
            brd_n     <= 1'b1;
            bwr_n     <= 1'b1;
            bd_out    <= '0;
            bd_oe     <= 1'b0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            busy      <= 1'b0;
            nosel_err <= 1'b0;
        end else begin
            rd_valid  <= 1'b0;
            nosel_err <= 1'b0;
            case (state)
                IDLE: if (rd_rise || wr_rise) begin
                    if (&cs_s2) begin
                        nosel_err <= 1'b1;
                        cnt       <= '0;
                        state     <= WAIT_REL;
                    end else begin
                        bcs_n  <= cs_s2;
                        baddr  <= addr_s2;
                        wr_acc <= wr_rise;
                        brd_n  <= wr_rise;
                        bwr_n  <= ~wr_rise;
                        bd_oe  <= wr_rise;
                        if (wr_rise) bd_out <= zd_in;
                        cnt    <= CW'(STB_LEN - 1);
                        busy   <= 1'b1;
                        state  <= ACTIVE;
                    end
                end
                ACTIVE: if (cnt == '0) begin
                    bcs_n <= '1;
                    brd_n <= 1'b1;
                    bwr_n <= 1'b1;
                    bd_oe <= 1'b0;
                    if (!wr_acc) begin
                        rd_data  <= bd_in;
                        rd_valid <= 1'b1;
                    end
                    cnt   <= CW'(REC_LEN > 0 ? REC_LEN - 1 : 0);
                    busy  <= REC_LEN > 0;
                    state <= REC_LEN > 0 ? RECOVER : WAIT_REL;
                end else cnt <= cnt - 1'b1;
                RECOVER: if (cnt == '0) begin
                    busy  <= 1'b0;
                    state <= WAIT_REL;
                end else cnt <= cnt - 1'b1;
                WAIT_REL: if (cnt != '0) cnt <= cnt - 1'b1;
                else if (rd_rel && wr_rel) state <= IDLE;
                default: state <= WAIT_REL;
            endcase
        end
    end
endmodule

// File: tb/tb_zbus_bufchan.sv
// tb_zbus_bufchan: table-driven accesses with a strobe scoreboard plus reset, glitch and timing corner cases
module tb_zbus_bufchan;
    localparam int STB = 5, REC = 1, STB2 = 3, REC2 = 4;

    logic       fclk = 1'b0, rst = 1'b1;
    logic       zrd_n = 1'b1, zwr_n = 1'b1;
    logic [1:0] req_cs_n = 2'b11;
    logic [9:0] req_addr = '0;
    logic [7:0] zd_in = '0, bd_in = '0;
    logic [1:0] bcs_n;
    logic [9:0] baddr;
    logic       brd_n, bwr_n, bd_oe, rd_valid, busy, nosel_err;
    logic [7:0] bd_out, rd_data;

    logic       z2_rd_n = 1'b1, z2_wr_n = 1'b1;
    logic [3:0] req2_cs_n = 4'hF;
    logic [9:0] req2_addr = 10'h12F;
    logic [7:0] zd2_in = 8'h6D, bd2_in = '0;
    logic [3:0] bcs2_n;
    logic [9:0] baddr2;
    logic       brd2_n, bwr2_n, bd2_oe, rd2_valid, busy2, nosel2_err;
    logic [7:0] bd2_out, rd2_data;

    zbus_bufchan #(.NCH(2), .AW(10), .DW(8), .STB_LEN(STB), .REC_LEN(REC)) dut (
        .fclk(fclk), .rst(rst), .zrd_n(zrd_n), .zwr_n(zwr_n), .req_cs_n(req_cs_n),
        .req_addr(req_addr), .zd_in(zd_in), .bd_in(bd_in), .bcs_n(bcs_n), .baddr(baddr),
        .brd_n(brd_n), .bwr_n(bwr_n), .bd_out(bd_out), .bd_oe(bd_oe), .rd_data(rd_data),
        .rd_valid(rd_valid), .busy(busy), .nosel_err(nosel_err)
    );

    zbus_bufchan #(.NCH(4), .AW(10), .DW(8), .STB_LEN(STB2), .REC_LEN(REC2)) dut2 (
        .fclk(fclk), .rst(rst), .zrd_n(z2_rd_n), .zwr_n(z2_wr_n), .req_cs_n(req2_cs_n),
        .req_addr(req2_addr), .zd_in(zd2_in), .bd_in(bd2_in), .bcs_n(bcs2_n), .baddr(baddr2),
        .brd_n(brd2_n), .bwr_n(bwr2_n), .bd_out(bd2_out), .bd_oe(bd2_oe), .rd_data(rd2_data),
        .rd_valid(rd2_valid), .busy(busy2), .nosel_err(nosel2_err)
    );

    always #5 fclk = ~fclk;

    typedef struct {bit wr; logic [1:0] cs; logic [9:0] addr; logic [7:0] data; int len; bit rdv;} exp_t;
    typedef struct {bit wr; logic [1:0] cs; logic [9:0] addr; logic [7:0] data; int hold;} vec_t;

    exp_t sb[$];
    exp_t e;
    vec_t vt[7];
    int n_chk = 0, n_fail = 0, n_pulse = 0, n_nosel = 0, n_rdv = 0, n_reads = 0;
    int plen = 0, plen2 = 0, blen2 = 0, gap2 = -1, n_pulse2 = 0;
    bit pwr;
    logic [1:0] pcs;
    logic [9:0] pad;
    logic [7:0] pdo;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic access(input bit wr, input logic [1:0] cs, input logic [9:0] a, input logic [7:0] d, input int hold);
        req_cs_n = cs;
        req_addr = a;
        if (wr) zd_in = d;
        else bd_in = d;
        repeat (3) @(posedge fclk);
        sb.push_back('{wr, cs, a, d, STB, !wr});
        if (!wr) n_reads++;
        #2;
        if (wr) zwr_n = 1'b0;
        else zrd_n = 1'b0;
        repeat (hold) @(posedge fclk);
        #2;
        zwr_n = 1'b1;
        zrd_n = 1'b1;
        repeat (15) @(posedge fclk);
        check("sb_drained", sb.size(), 0);
    endtask

    // scoreboard monitor for the main instance: one queued expectation per completed strobe
    always @(negedge fclk) begin
        if (nosel_err === 1'b1) n_nosel++;
        if (rd_valid === 1'b1) n_rdv++;
        if (brd_n === 1'b0 || bwr_n === 1'b0) begin
            if (plen == 0) begin
                pwr = !bwr_n;
                pcs = bcs_n;
                pad = baddr;
                pdo = bd_out;
            end
            plen++;
            check("cs_stable", bcs_n, pcs);
            check("bd_oe_in_strobe", bd_oe, !bwr_n);
            check("busy_in_strobe", busy, 1);
        end else if (plen != 0) begin
            n_pulse++;
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_strobe: got pulse len %0d expected none at %0t", plen, $time);
            end else begin
                e = sb.pop_front();
                check("strobe_len", plen, e.len);
                check("strobe_kind", pwr, e.wr);
                check("bcs_n", pcs, e.cs);
                check("baddr", pad, e.addr);
                if (e.wr) check("bd_out", pdo, e.data);
                if (e.rdv) check("rd_data", rd_data, e.data);
                check("rd_valid", rd_valid, e.rdv);
            end
            check("bd_oe_after", bd_oe, 0);
            plen = 0;
        end
    end

    // timing monitor for the NCH=4 instance: strobe width, recovery gap and busy window
    always @(negedge fclk) begin
        if (bwr2_n === 1'b0) begin
            if (plen2 == 0 && gap2 >= 0) check("gap2_min", gap2 >= REC2, 1);
            plen2++;
            check("busy2_in_strobe", busy2, 1);
            check("bcs2_n", bcs2_n, 4'b1011);
            check("bd2_out", bd2_out, 8'h6D);
        end else if (plen2 != 0) begin
            n_pulse2++;
            check("len2", plen2, STB2);
            plen2 = 0;
            gap2 = 1;
        end else if (gap2 >= 0) gap2++;
        if (busy2 === 1'b1) blen2++;
        else if (blen2 != 0) begin
            check("busy2_len", blen2, STB2 + REC2);
            blen2 = 0;
        end
    end

    initial begin
        int p0, q0, k;
        vt[0] = '{1'b1, 2'b10, 10'h155, 8'hA5, 20};
        vt[1] = '{1'b0, 2'b01, 10'h2AA, 8'h3C, 12};
        vt[2] = '{1'b1, 2'b01, 10'h3FF, 8'h5A, 8};
        vt[3] = '{1'b0, 2'b10, 10'h000, 8'hC3, 8};
        vt[4] = '{1'b1, 2'b00, 10'h0F0, 8'hFF, 10};
        vt[5] = '{1'b1, 2'b10, 10'h1E1, 8'h24, 100};
        vt[6] = '{1'b0, 2'b01, 10'h123, 8'h81, 100};

        repeat (3) @(negedge fclk);
        check("rst_bcs_n", bcs_n, 2'b11);
        check("rst_brd_n", brd_n, 1);
        check("rst_bwr_n", bwr_n, 1);
        check("rst_bd_oe", bd_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_nosel", nosel_err, 0);
        check("rst_baddr", baddr, 0);
        check("rst_rd_data", rd_data, 0);
        rst = 1'b0;
        repeat (6) @(posedge fclk);

        for (int i = 0; i < 7; i++) access(vt[i].wr, vt[i].cs, vt[i].addr, vt[i].data, vt[i].hold);

        req_cs_n = 2'b10;
        req_addr = 10'h077;
        zd_in = 8'h99;
        bd_in = 8'h11;
        q0 = n_rdv;
        repeat (3) @(posedge fclk);
        sb.push_back('{1'b1, 2'b10, 10'h077, 8'h99, STB, 1'b0});
        #2;
        zwr_n = 1'b0;
        zrd_n = 1'b0;
        repeat (10) @(posedge fclk);
        #2;
        zwr_n = 1'b1;
        zrd_n = 1'b1;
        repeat (15) @(posedge fclk);
        check("both_drained", sb.size(), 0);
        check("both_no_read", n_rdv, q0);

        p0 = n_pulse;
        q0 = n_nosel;
        req_cs_n = 2'b01;
        repeat (3) @(posedge fclk);
        #2 zrd_n = 1'b0;
        #10 zrd_n = 1'b1;
        repeat (10) @(posedge fclk);
        check("glitch_no_strobe", n_pulse, p0);
        check("glitch_no_nosel", n_nosel, q0);

        req_cs_n = 2'b11;
        repeat (3) @(posedge fclk);
        #2 zrd_n = 1'b0;
        repeat (10) @(posedge fclk);
        #2 zrd_n = 1'b1;
        repeat (10) @(posedge fclk);
        check("nosel_pulse", n_nosel, q0 + 1);
        check("nosel_no_strobe", n_pulse, p0);

        req_cs_n = 2'b01;
        req_addr = 10'h0AA;
        bd_in = 8'h5E;
        q0 = n_rdv;
        repeat (3) @(posedge fclk);
        sb.push_back('{1'b0, 2'b01, 10'h0AA, 8'h5E, 3, 1'b0});
        #2 zrd_n = 1'b0;
        k = 0;
        while (brd_n !== 1'b0 && k < 20) begin
            @(negedge fclk);
            k++;
        end
        check("rst_case_strobe_seen", brd_n, 0);
        @(negedge fclk);
        @(negedge fclk);
        rst = 1'b1;
        @(negedge fclk);
        rst = 1'b0;
        check("midrst_bcs_n", bcs_n, 2'b11);
        check("midrst_brd_n", brd_n, 1);
        check("midrst_busy", busy, 0);
        check("midrst_baddr", baddr, 0);
        check("midrst_rd_data", rd_data, 0);
        @(negedge fclk);
        p0 = n_pulse;
        repeat (25) @(posedge fclk);
        check("midrst_no_reissue", n_pulse, p0);
        check("midrst_no_rd_valid", n_rdv, q0);
        sb.push_back('{1'b0, 2'b01, 10'h0AA, 8'h5E, STB, 1'b1});
        n_reads++;
        #2 zrd_n = 1'b1;
        repeat (5) @(posedge fclk);
        #2 zrd_n = 1'b0;
        repeat (12) @(posedge fclk);
        #2 zrd_n = 1'b1;
        repeat (15) @(posedge fclk);
        check("midrst_fresh_edge", sb.size(), 0);
        check("reads_total", n_rdv, n_reads);

        req2_cs_n = 4'b1011;
        repeat (3) @(posedge fclk);
        for (int i = 0; i < 3; i++) begin
            #2 z2_wr_n = 1'b0;
            repeat (10) @(posedge fclk);
            #2 z2_wr_n = 1'b1;
            repeat (5) @(posedge fclk);
        end
        repeat (15) @(posedge fclk);
        check("pulses2", n_pulse2, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
